// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the FIFO: issues pops, drives the wrapping read
// address, and holds each popped word in a valid/ready output register.
// A consumer that stalls too long raises a sticky timeout flag.
module fifo_read_ctrl #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MEM_DEPTH  = 4,
    parameter  int unsigned STALL_MAX  = 15,
    localparam int unsigned ADDR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  pop,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  stall_to
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  stall_to_q, stall_to_d;
    logic                  xfer;
    logic                  stalled;

    // Next-state, pop strobe and datapath updates.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        stall_to_d  = stall_to_q;

        xfer    = out_valid_q & out_ready;
        stalled = (state_q != IDLE) & ~out_ready;
        pop     = reset & ~flush & ~empty & (~out_valid_q | out_ready);

        if (flush) begin
            // Flush drops the held word but keeps out_data as it was.
            state_d     = IDLE;
            rd_addr_d   = '0;
            out_valid_d = 1'b0;
            stall_cnt_d = '0;
            stall_to_d  = 1'b0;
        end else begin
            if (pop) begin
                out_data_d  = mem_data;
                out_valid_d = 1'b1;
                rd_addr_d   = (rd_addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0
                                                                    : rd_addr_q + ADDR_W'(1);
            end else if (xfer) begin
                out_valid_d = 1'b0;
            end

            if (xfer) begin
                stall_cnt_d = '0;
            end else if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end

            if (stall_cnt_d == CNT_W'(STALL_MAX)) begin
                stall_to_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pop) state_d = LOAD;
                end
                LOAD: begin
                    if (xfer && !pop)    state_d = IDLE;
                    else if (!out_ready) state_d = STALL;
                end
                STALL: begin
                    if (xfer) state_d = pop ? LOAD : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            stall_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            stall_to_q  <= stall_to_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign stall_to  = stall_to_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Testbench for fifo_read_ctrl: directed table, corner sequences and a
// randomized run against a behavioural model, on depth-4 and depth-5 instances.
module tb_fifo_read_ctrl;

    localparam int STALL_MAX = 15;

    logic       clk;
    logic       reset;
    logic       empty;
    logic       flush;
    logic       out_ready;

    logic       pop4, valid4, to4;
    logic [1:0] addr4;
    logic [7:0] data4, mdata4;
    logic       pop5, valid5, to5;
    logic [2:0] addr5;
    logic [7:0] data5, mdata5;

    logic [7:0] mem4 [4];
    logic [7:0] mem5 [5];

    int checks = 0;
    int errors = 0;

    assign mdata4 = mem4[addr4];
    assign mdata5 = (addr5 < 3'd5) ? mem5[addr5] : 8'hxx;

    fifo_read_ctrl #(.DATA_WIDTH(8), .MEM_DEPTH(4), .STALL_MAX(STALL_MAX)) u_dut4 (
        .clk(clk), .reset(reset), .empty(empty), .mem_data(mdata4), .flush(flush),
        .out_ready(out_ready), .pop(pop4), .rd_addr(addr4), .out_data(data4),
        .out_valid(valid4), .stall_to(to4)
    );

    fifo_read_ctrl #(.DATA_WIDTH(8), .MEM_DEPTH(5), .STALL_MAX(STALL_MAX)) u_dut5 (
        .clk(clk), .reset(reset), .empty(empty), .mem_data(mdata5), .flush(flush),
        .out_ready(out_ready), .pop(pop5), .rd_addr(addr5), .out_data(data5),
        .out_valid(valid5), .stall_to(to5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 2ns later.
    task automatic cyc(input bit r, input bit e, input bit f, input bit rdy);
        @(negedge clk);
        reset = r; empty = e; flush = f; out_ready = rdy;
        #2;
    endtask

    // Behavioural model: read pointer counts modulo depth, stall counts consecutive
    // cycles a valid word waits, timeout latches once that count reaches STALL_MAX.
    typedef struct {
        bit         v;
        logic [7:0] d;
        int         a;
        int         c;
        bit         t;
    } mdl_t;

    mdl_t m [2];
    int   depth [2] = '{4, 5};

    function automatic bit mpop(input int i);
        return reset & ~flush & ~empty & (~m[i].v | out_ready);
    endfunction

    task automatic mstep(input int i);
        bit p, x;
        p = mpop(i);
        x = m[i].v & out_ready;
        if (!reset) begin
            m[i] = '{v: 1'b0, d: 8'h00, a: 0, c: 0, t: 1'b0};
        end else if (flush) begin
            m[i].v = 1'b0; m[i].a = 0; m[i].c = 0; m[i].t = 1'b0;
        end else begin
            if (x) m[i].c = 0;
            else if (m[i].v) m[i].c = (m[i].c + 1 > 255) ? 255 : m[i].c + 1;
            if (m[i].c >= STALL_MAX) m[i].t = 1'b1;
            if (p) begin
                m[i].d = (i == 0) ? mem4[m[i].a] : mem5[m[i].a];
                m[i].v = 1'b1;
                m[i].a = (m[i].a + 1) % depth[i];
            end else if (x) begin
                m[i].v = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit         r, e, f, rdy;
        bit         p, v;
        logic [7:0] d;
        logic [1:0] a;
        bit         t;
    } vec_t;

    vec_t vecs [15];

    initial begin
        reset = 1'b0; empty = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem4[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 5; i++) mem5[i] = 8'hB0 + 8'(i);

        // Reset hold, streaming A0..A3, drain, then backpressure on A0.
        for (int i = 0; i < 3; i++) vecs[i] = '{0,0,0,1, 0,0, 8'h00, 2'd0, 0};
        vecs[3]  = '{1,0,0,1, 1,0, 8'h00, 2'd0, 0};
        vecs[4]  = '{1,0,0,1, 1,1, 8'hA0, 2'd1, 0};
        vecs[5]  = '{1,0,0,1, 1,1, 8'hA1, 2'd2, 0};
        vecs[6]  = '{1,0,0,1, 1,1, 8'hA2, 2'd3, 0};
        vecs[7]  = '{1,1,0,1, 0,1, 8'hA3, 2'd0, 0};
        vecs[8]  = '{1,1,0,1, 0,0, 8'hA3, 2'd0, 0};
        vecs[9]  = '{1,0,0,1, 1,0, 8'hA3, 2'd0, 0};
        for (int i = 10; i < 15; i++) vecs[i] = '{1,0,0,0, 0,1, 8'hA0, 2'd1, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].rdy);
            chk($sformatf("vec%0d pop", i),   32'(pop4),   32'(vecs[i].p));
            chk($sformatf("vec%0d valid", i), 32'(valid4), 32'(vecs[i].v));
            chk($sformatf("vec%0d data", i),  32'(data4),  32'(vecs[i].d));
            chk($sformatf("vec%0d addr", i),  32'(addr4),  32'(vecs[i].a));
            chk($sformatf("vec%0d to", i),    32'(to4),    32'(vecs[i].t));
        end

        // Continue the stall: cycles 6..20, timeout visible after 15 stalled edges.
        for (int k = 6; k <= 20; k++) begin
            cyc(1, 0, 0, 0);
            chk($sformatf("stall%0d to", k),    32'(to4),    32'(k >= 16));
            chk($sformatf("stall%0d valid", k), 32'(valid4), 32'(1));
            chk($sformatf("stall%0d pop", k),   32'(pop4),   32'(0));
            chk($sformatf("stall%0d data", k),  32'(data4),  32'(8'hA0));
        end
        cyc(1, 1, 0, 1);
        chk("release to", 32'(to4), 32'(1));
        chk("release valid", 32'(valid4), 32'(1));
        cyc(1, 1, 0, 1);
        chk("sticky to", 32'(to4), 32'(1));
        chk("drained valid", 32'(valid4), 32'(0));

        // Flush while a word is valid and the consumer is ready.
        cyc(1, 0, 0, 1);
        chk("prefl pop", 32'(pop4), 32'(1));
        chk("prefl addr", 32'(addr4), 32'(1));
        cyc(1, 0, 1, 1);
        chk("flush pop", 32'(pop4), 32'(0));
        chk("flush in valid", 32'(valid4), 32'(1));
        chk("flush in data", 32'(data4), 32'(8'hA1));
        cyc(1, 0, 0, 0);
        chk("postfl valid", 32'(valid4), 32'(0));
        chk("postfl addr", 32'(addr4), 32'(0));
        chk("postfl to", 32'(to4), 32'(0));
        chk("postfl data", 32'(data4), 32'(8'hA1));
        chk("postfl pop", 32'(pop4), 32'(1));

        // Reset pulsed mid-stream.
        cyc(1, 0, 0, 1);
        chk("mid valid", 32'(valid4), 32'(1));
        chk("mid data", 32'(data4), 32'(8'hA0));
        cyc(0, 0, 0, 1);
        chk("midrst pop", 32'(pop4), 32'(0));
        cyc(1, 1, 0, 1);
        chk("midrst valid", 32'(valid4), 32'(0));
        chk("midrst data", 32'(data4), 32'(0));
        chk("midrst addr", 32'(addr4), 32'(0));
        chk("midrst to", 32'(to4), 32'(0));

        // Depth-5 wrap: rd_addr 0,1,2,3,4,0,1,2 across 7 pops.
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 0, 1);
            chk($sformatf("wrap5 addr%0d", k), 32'(addr5), 32'(k % 5));
            if (k > 0) chk($sformatf("wrap5 data%0d", k), 32'(data5), 32'(8'hB0 + 8'((k - 1) % 5)));
        end

        // Randomized run against the model on both instances.
        for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) mem5[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            bit r, e, f, rdy;
            r   = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            f   = ($urandom_range(0, 49) == 0);
            e   = ($urandom_range(0, 9) < 4);
            rdy = (n % 200 < 40) ? 1'b0 : ($urandom_range(0, 9) < 6);
            cyc(r, e, f, rdy);
            if (n > 0) begin
                chk("rnd4 pop",   32'(pop4),   32'(mpop(0)));
                chk("rnd4 valid", 32'(valid4), 32'(m[0].v));
                chk("rnd4 data",  32'(data4),  32'(m[0].d));
                chk("rnd4 addr",  32'(addr4),  32'(m[0].a));
                chk("rnd4 to",    32'(to4),    32'(m[0].t));
                chk("rnd5 pop",   32'(pop5),   32'(mpop(1)));
                chk("rnd5 valid", 32'(valid5), 32'(m[1].v));
                chk("rnd5 data",  32'(data5),  32'(m[1].d));
                chk("rnd5 addr",  32'(addr5),  32'(m[1].a));
                chk("rnd5 to",    32'(to5),    32'(m[1].t));
            end
            mstep(0);
            mstep(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
